// File: rtl/redstone_change_reporter.sv
// Snapshots N redstone component outputs on every accepted tick and streams one (index, value)
// event per changed bit, lowest index first. Optional macro SCAN_FULL_DUMP_EN adds i_dump.
module redstone_change_reporter #(
  parameter int           N     = 64,
  parameter int           IDX_W = 6,
  parameter logic [N-1:0] INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [N-1:0]     i_state,
`ifdef SCAN_FULL_DUMP_EN
  input  logic             i_dump,
`endif
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index,
  output logic             o_value,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_tick_done,
  output logic             o_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_prev;
  logic [N-1:0]   r_snap;
  logic [N-1:0]   r_pending;

  logic [N-1:0]     w_tickDiff;
  logic [N-1:0]     w_scanPending;
  logic [N-1:0]     w_nextPending;
  logic [N-1:0]     w_nextSnap;
  logic             w_nextFound;
  logic [IDX_W-1:0] w_nextIndex;
  logic             w_nextValue;

  always_comb begin
    w_tickDiff = i_state ^ r_prev;
`ifdef SCAN_FULL_DUMP_EN
    if (i_dump) w_tickDiff = '1;
`endif
  end

  // The registered outputs always show the lowest bit still pending after this edge, so the
  // first event appears the cycle after the tick and a stalled event never moves.
  always_comb begin
    w_scanPending = r_pending;
    if (o_valid && i_ready) w_scanPending = r_pending & ~(N'(1) << o_index);
    w_nextPending = (r_state == IDLE) ? w_tickDiff : w_scanPending;
    w_nextSnap    = (r_state == IDLE) ? i_state : r_snap;
  end

  always_comb begin
    w_nextFound = 1'b0;
    w_nextIndex = '0;
    w_nextValue = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_nextPending[i]) begin
        w_nextFound = 1'b1;
        w_nextIndex = IDX_W'(i);
        w_nextValue = w_nextSnap[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_prev      <= INIT;
      r_snap      <= '0;
      r_pending   <= '0;
      o_valid     <= 1'b0;
      o_index     <= '0;
      o_value     <= 1'b0;
      o_busy      <= 1'b0;
      o_tick_done <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_tick_done <= 1'b0;
      if (i_tick && r_state != IDLE) o_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_tick) begin
            r_snap    <= i_state;
            r_prev    <= i_state;
            r_pending <= w_nextPending;
            o_valid   <= w_nextFound;
            o_index   <= w_nextIndex;
            o_value   <= w_nextValue;
            o_busy    <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (r_pending == '0) begin
            o_tick_done <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_pending <= w_scanPending;
            o_valid   <= w_nextFound;
            o_index   <= w_nextIndex;
            o_value   <= w_nextValue;
          end
        end
        DONE: begin
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redstone_change_reporter.sv
// Directed bench for redstone_change_reporter: a queue-based event model checked every cycle,
// plus literal expectations for the key tick scenarios.
module tb_redstone_change_reporter;

  logic        clk;
  logic        rstN;
  logic        tick;
  logic [63:0] stateIn;
  logic        ready;
`ifdef SCAN_FULL_DUMP_EN
  logic        dump;
`endif
  logic        oValid;
  logic [5:0]  oIndex;
  logic        oValue;
  logic        oBusy;
  logic        oTickDone;
  logic        oOverrun;

  int errCount   = 0;
  int checkCount = 0;

  redstone_change_reporter #(.N(64), .IDX_W(6), .INIT('0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_tick      (tick),
    .i_state     (stateIn),
`ifdef SCAN_FULL_DUMP_EN
    .i_dump      (dump),
`endif
    .o_valid     (oValid),
    .o_index     (oIndex),
    .o_value     (oValue),
    .i_ready     (ready),
    .o_busy      (oBusy),
    .o_tick_done (oTickDone),
    .o_overrun   (oOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted tick turns the net change into an ordered event list;
  // each event is shown until accepted, then one empty cycle, then one done cycle.
  typedef struct packed {logic [5:0] idx; logic val;} event_t;
  event_t      evQ[$];
  int          mStage = 0;
  logic [63:0] mPrev  = '0;
  logic [63:0] mDiff;
  logic        mOvr   = 1'b0;
  logic        modelLive = 1'b0;

  always @(posedge clk) begin
    modelLive = 1'b1;
    if (!rstN) begin
      evQ.delete();
      mStage = 0;
      mPrev  = '0;
      mOvr   = 1'b0;
    end else begin
      if (tick && mStage != 0) mOvr = 1'b1;
      case (mStage)
        0: if (tick) begin
          mDiff = stateIn ^ mPrev;
`ifdef SCAN_FULL_DUMP_EN
          if (dump) mDiff = '1;
`endif
          for (int i = 0; i < 64; i++)
            if (mDiff[i]) evQ.push_back({6'(i), stateIn[i]});
          mPrev  = stateIn;
          mStage = 1;
        end
        1: begin
          if (evQ.size() > 0) begin
            if (ready) void'(evQ.pop_front());
          end else begin
            mStage = 2;
          end
        end
        default: mStage = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model valid", 64'(oValid), 64'(evQ.size() > 0 && mStage == 1));
      if (evQ.size() > 0 && mStage == 1) begin
        checkOutput("model index", 64'(oIndex), 64'(evQ[0].idx));
        checkOutput("model value", 64'(oValue), 64'(evQ[0].val));
      end
      checkOutput("model busy", 64'(oBusy), 64'(mStage != 0));
      checkOutput("model tick_done", 64'(oTickDone), 64'(mStage == 2));
      checkOutput("model overrun", 64'(oOverrun), 64'(mOvr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic t, input logic [63:0] s, input logic r);
    tick    = t;
    stateIn = s;
    ready   = r;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (oBusy && n < 300) begin
      step();
      n++;
    end
    if (oBusy) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL waitIdle timeout: busy=%0b required 0", oBusy);
    end
  endtask

  logic [63:0] curState;

  initial begin
    rstN    = 1'b0;
    curState = '0;
    applyStimulus(0, '0, 1);
`ifdef SCAN_FULL_DUMP_EN
    dump = 1'b0;
`endif
    step();
    step();
    checkOutput("reset valid", 64'(oValid), 0);
    checkOutput("reset busy", 64'(oBusy), 0);
    checkOutput("reset overrun", 64'(oOverrun), 0);
    rstN = 1'b1;
    step();

    // No-change tick
    applyStimulus(1, 64'h0, 1);
    step();
    applyStimulus(0, 64'h0, 1);
    checkOutput("t1 valid t+1", 64'(oValid), 0);
    step();
    checkOutput("t1 done t+2", 64'(oTickDone), 1);
    step();
    checkOutput("t1 busy t+3", 64'(oBusy), 0);

    // Three changes, consumer always ready
    curState = 64'h8000_0000_0000_0005;
    applyStimulus(1, curState, 1);
    step();
    applyStimulus(0, curState, 1);
    checkOutput("t2 ev0 index", 64'(oIndex), 0);
    checkOutput("t2 ev0 value", 64'(oValue), 1);
    step();
    checkOutput("t2 ev1 index", 64'(oIndex), 2);
    step();
    checkOutput("t2 ev2 index", 64'(oIndex), 63);
    checkOutput("t2 ev2 valid", 64'(oValid), 1);
    step();
    checkOutput("t2 t+4 valid", 64'(oValid), 0);
    step();
    checkOutput("t2 done t+5", 64'(oTickDone), 1);
    step();

    // Clear everything, then repeat with a stalled consumer
    curState = 64'h0;
    applyStimulus(1, curState, 1);
    step();
    applyStimulus(0, curState, 1);
    waitIdle();
    curState = 64'h8000_0000_0000_0005;
    applyStimulus(1, curState, 0);
    step();
    applyStimulus(0, curState, 0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("t3 stall index", 64'(oIndex), 0);
      checkOutput("t3 stall value", 64'(oValue), 1);
      checkOutput("t3 stall valid", 64'(oValid), 1);
      step();
    end
    applyStimulus(0, curState, 1);
    checkOutput("t3 release index", 64'(oIndex), 0);
    step();
    checkOutput("t3 second index", 64'(oIndex), 2);
    step();
    checkOutput("t3 third index", 64'(oIndex), 63);
    waitIdle();

    // Dropped tick while busy; bit 1 toggles and returns, so only bit 10 is reported later
    applyStimulus(1, curState | 64'h10, 0);
    step();
    applyStimulus(1, curState | 64'h12, 0);
    step();
    applyStimulus(0, curState | 64'h12, 0);
    checkOutput("t4 overrun", 64'(oOverrun), 1);
    ready = 1'b1;
    waitIdle();
    curState = curState | 64'h410;
    applyStimulus(1, curState, 1);
    step();
    applyStimulus(0, curState, 1);
    checkOutput("t4 net index", 64'(oIndex), 10);
    checkOutput("t4 net value", 64'(oValue), 1);
    step();
    checkOutput("t4 single event", 64'(oValid), 0);
    waitIdle();

    // Reset in the middle of a scan
    applyStimulus(1, curState ^ 64'h30_0000, 0);
    step();
    applyStimulus(0, curState ^ 64'h30_0000, 0);
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    checkOutput("t5 valid", 64'(oValid), 0);
    checkOutput("t5 busy", 64'(oBusy), 0);
    checkOutput("t5 overrun", 64'(oOverrun), 0);
    step();

    // Tick coinciding with the done cycle is dropped
    applyStimulus(1, 64'h0, 1);
    step();
    applyStimulus(0, 64'h0, 1);
    step();
    checkOutput("t7 done", 64'(oTickDone), 1);
    applyStimulus(1, 64'h80, 1);
    step();
    applyStimulus(0, 64'h80, 1);
    checkOutput("t7 dropped busy", 64'(oBusy), 0);
    checkOutput("t7 dropped overrun", 64'(oOverrun), 1);
    applyStimulus(1, 64'h80, 1);
    step();
    applyStimulus(0, 64'h80, 1);
    checkOutput("t7 late index", 64'(oIndex), 7);
    waitIdle();

`ifdef SCAN_FULL_DUMP_EN
    applyStimulus(1, 64'h3, 1);
    dump = 1'b1;
    step();
    applyStimulus(0, 64'h3, 1);
    dump = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checkOutput("t6 dump valid", 64'(oValid), 1);
      checkOutput("t6 dump index", 64'(oIndex), 64'(i));
      checkOutput("t6 dump value", 64'(oValue), 64'(i < 2));
      step();
    end
    checkOutput("t6 dump end", 64'(oValid), 0);
    waitIdle();
`endif

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
